// File: rtl/register_pkg.sv
// Shared sizing and state encoding for the register index encoder.
package register_pkg;
    localparam int N_REGS = 32;
    localparam int IDX_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/lsb_encoder.sv
// Combinational lowest-set-bit search: returns index of the lowest set bit and whether any bit is set.
module lsb_encoder #(
    parameter int N_REGS = 32,
    parameter int IDX_W  = 5
) (
    input  logic [N_REGS-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);
    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is the last (winning) assignment.
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    assign any = |mask;
endmodule

// File: rtl/register_encoder.sv
// Walks a register mask and emits the index of each set bit in ascending order, one per handshake.
module register_encoder #(
    parameter int N_REGS = register_pkg::N_REGS,
    parameter int IDX_W  = register_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [N_REGS-1:0] load_mask,
    input  logic              abort,
    output logic              idx_valid,
    input  logic              idx_ready,
    output logic [IDX_W-1:0]  idx,
    output logic [N_REGS-1:0] idx_onehot,
    output logic              idx_last,
    output logic [IDX_W:0]    remaining,
    output logic              done
);
    import register_pkg::*;

    state_t            state;
    logic [N_REGS-1:0] mask;
    logic [N_REGS-1:0] mask_nxt;
    logic              done_nxt;
    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;
    logic [N_REGS-1:0] onehot_nxt;
    logic [IDX_W:0]    cnt_nxt;

    assign load_ready = (state == IDLE);

    always_comb begin
        mask_nxt = mask;
        done_nxt = 1'b0;
        if (abort) begin
            mask_nxt = '0;
        end else if (state == IDLE) begin
            if (load_valid) begin
                mask_nxt = load_mask;
                done_nxt = (load_mask == '0);
            end
        end else if (idx_valid && idx_ready) begin
            mask_nxt = mask & ~idx_onehot;
            done_nxt = idx_last;
        end
    end

    // Outputs are computed from the next mask and registered, so they change only on a clock edge.
    lsb_encoder #(.N_REGS(N_REGS), .IDX_W(IDX_W)) u_lsb (
        .mask (mask_nxt),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    assign onehot_nxt = enc_any ? (N_REGS'(1) << enc_idx) : '0;

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < N_REGS; i++) begin
            cnt_nxt = cnt_nxt + {{IDX_W{1'b0}}, mask_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            idx_valid  <= 1'b0;
            idx        <= '0;
            idx_onehot <= '0;
            idx_last   <= 1'b0;
            remaining  <= '0;
            done       <= 1'b0;
        end else begin
            state      <= enc_any ? EMIT : IDLE;
            mask       <= mask_nxt;
            idx_valid  <= enc_any;
            idx        <= enc_idx;
            idx_onehot <= onehot_nxt;
            idx_last   <= (cnt_nxt == (IDX_W+1)'(1));
            remaining  <= cnt_nxt;
            done       <= done_nxt;
        end
    end
endmodule

// File: tb/tb_register_encoder.sv
// Directed table-driven bench for register_encoder plus hand-written stall/abort/reset sequences.
module tb_register_encoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_mask;
    logic        abort;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic [31:0] idx_onehot;
    logic        idx_last;
    logic [5:0]  remaining;
    logic        done;

    int n_chk = 0;
    int n_pass = 0;

    register_encoder #(.N_REGS(32), .IDX_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_mask  (load_mask),
        .abort      (abort),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .idx        (idx),
        .idx_onehot (idx_onehot),
        .idx_last   (idx_last),
        .remaining  (remaining),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        logic [4:0]  first;
        logic [5:0]  pop;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int popc(input logic [31:0] m);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic check_idle(input string nm, input logic exp_done);
        chk({nm, "_valid"}, 32'(idx_valid), 32'd0);
        chk({nm, "_rem"},   32'(remaining), 32'd0);
        chk({nm, "_oh"},    idx_onehot,     32'd0);
        chk({nm, "_lr"},    32'(load_ready), 32'd1);
        chk({nm, "_done"},  32'(done),      32'(exp_done));
    endtask

    // Load one mask with idx_ready held high and walk every emitted index against a lowest-bit model.
    task automatic run_job(input logic [31:0] m, input logic [4:0] f, input logic [5:0] p);
        logic [31:0] mdl;
        int          b;
        int          n;
        mdl = m;
        n = 0;
        load_valid = 1'b1;
        load_mask  = m;
        idx_ready  = 1'b1;
        step();
        load_valid = 1'b0;
        if (m == 32'd0) begin
            check_idle("zero", 1'b1);
            step();
            chk("zero_done_clr", 32'(done), 32'd0);
            return;
        end
        chk("first_idx", 32'(idx), 32'(f));
        chk("first_rem", 32'(remaining), 32'(p));
        while (mdl != 32'd0 && n < 40) begin
            b = 0;
            for (int i = 31; i >= 0; i--) if (mdl[i]) b = i;
            chk("walk_valid", 32'(idx_valid), 32'd1);
            chk("walk_idx",   32'(idx), 32'(b));
            chk("walk_oh",    idx_onehot, 32'd1 << b);
            chk("walk_last",  32'(idx_last), 32'(popc(mdl) == 1));
            chk("walk_rem",   32'(remaining), 32'(popc(mdl)));
            chk("walk_done",  32'(done), 32'd0);
            chk("walk_lr",    32'(load_ready), 32'd0);
            mdl[b] = 1'b0;
            n++;
            step();
        end
        chk("job_len", 32'(n), 32'(p));
        check_idle("end", 1'b1);
        step();
        chk("done_clr", 32'(done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h8000_0011, 5'd0,  6'd3};
        tbl[1] = '{32'h0000_0000, 5'd0,  6'd0};
        tbl[2] = '{32'hFFFF_FFFF, 5'd0,  6'd32};
        tbl[3] = '{32'h0000_0001, 5'd0,  6'd1};
        tbl[4] = '{32'h8000_0000, 5'd31, 6'd1};
        tbl[5] = '{32'hA5A5_0F00, 5'd8,  6'd12};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_mask  = '0;
        abort      = 1'b0;
        idx_ready  = 1'b0;
        #3;
        check_idle("rst", 1'b0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_last", 32'(idx_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 6; k++) run_job(tbl[k].mask, tbl[k].first, tbl[k].pop);

        // Stall: idx must hold while idx_ready is low, and a load offered mid-job is ignored.
        load_valid = 1'b1;
        load_mask  = 32'h0000_0006;
        idx_ready  = 1'b0;
        step();
        load_mask = 32'h0000_0080;
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", 32'(idx_valid), 32'd1);
            chk("stall_idx",   32'(idx), 32'd1);
            chk("stall_oh",    idx_onehot, 32'h2);
            chk("stall_rem",   32'(remaining), 32'd2);
            chk("stall_last",  32'(idx_last), 32'd0);
            step();
        end
        load_valid = 1'b0;
        idx_ready  = 1'b1;
        step();
        chk("stall_idx2",  32'(idx), 32'd2);
        chk("stall_last2", 32'(idx_last), 32'd1);
        chk("stall_rem2",  32'(remaining), 32'd1);
        step();
        check_idle("stall_end", 1'b1);
        step();

        // Abort after idx 4 is accepted: no done, back to idle; abort also blocks a load in idle.
        load_valid = 1'b1;
        load_mask  = 32'h0000_00F0;
        step();
        load_valid = 1'b0;
        chk("ab_idx4", 32'(idx), 32'd4);
        step();
        chk("ab_idx5", 32'(idx), 32'd5);
        abort = 1'b1;
        step();
        check_idle("ab", 1'b0);
        load_valid = 1'b1;
        load_mask  = 32'h0000_0001;
        step();
        check_idle("ab_blk", 1'b0);
        abort = 1'b0;
        step();
        load_valid = 1'b0;
        chk("ab_new_valid", 32'(idx_valid), 32'd1);
        chk("ab_new_idx",   32'(idx), 32'd0);
        chk("ab_new_last",  32'(idx_last), 32'd1);
        step();
        check_idle("ab_new_end", 1'b1);
        step();

        // Reset mid-job: outputs drop at once, no done, first load accepted right after release.
        load_valid = 1'b1;
        load_mask  = 32'h0000_0300;
        step();
        load_valid = 1'b0;
        chk("rj_idx8", 32'(idx), 32'd8);
        step();
        chk("rj_idx9", 32'(idx), 32'd9);
        rst_n = 1'b0;
        #1;
        check_idle("rj", 1'b0);
        chk("rj_idx", 32'(idx), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        load_valid = 1'b1;
        load_mask  = 32'h0000_0001;
        step();
        load_valid = 1'b0;
        chk("rj_new_valid", 32'(idx_valid), 32'd1);
        chk("rj_new_idx",   32'(idx), 32'd0);
        chk("rj_new_done",  32'(done), 32'd0);
        step();
        check_idle("rj_end", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/register_encoder.md
REGISTER_ENCODER -- requirements
Module: register_encoder

Interface
REQ-001 SHALL have parameter N_REGS, default 32: width of register mask.
REQ-002 SHALL have parameter IDX_W, default 5: width of register index; N_REGS == 2**IDX_W.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port load_valid, input, 1: a new mask is offered.
REQ-006 SHALL have port load_ready, output, 1: block accepts a mask this cycle.
REQ-007 SHALL have port load_mask, input, N_REGS: one bit per register to be emitted.
REQ-008 SHALL have port abort, input, 1: synchronous flush of the current job.
REQ-009 SHALL have port idx_valid, output, 1: idx is valid.
REQ-010 SHALL have port idx_ready, input, 1: consumer accepts idx.
REQ-011 SHALL have port idx, output, IDX_W: encoded register index.
REQ-012 SHALL have port idx_onehot, output, N_REGS: one-hot of idx, all-zero when idx_valid=0.
REQ-013 SHALL have port idx_last, output, 1: current idx is the final one of the job.
REQ-014 SHALL have port remaining, output, IDX_W+1: popcount of bits not yet emitted.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at job completion.

Function
REQ-016 SHALL implement two states, IDLE and EMIT.
REQ-017 In IDLE, load_ready SHALL be 1 and idx_valid SHALL be 0. In EMIT, load_ready SHALL be 0.
REQ-018 On load_valid&&load_ready with load_mask!=0, the block SHALL register the mask and enter EMIT; idx_valid SHALL rise the next cycle (1-cycle latency).
REQ-019 On load_valid&&load_ready with load_mask==0, the block SHALL stay in IDLE and pulse done the next cycle.
REQ-020 In EMIT, idx SHALL be the lowest-numbered set bit of the registered mask (ascending order).
REQ-021 idx, idx_onehot, idx_last SHALL be held stable while idx_valid&&!idx_ready.
REQ-022 On idx_valid&&idx_ready, the emitted bit SHALL be cleared, and the next index SHALL be presented the following cycle (throughput 1 index/cycle with idx_ready held high).
REQ-023 idx_last SHALL be 1 exactly when remaining==1 in EMIT.
REQ-024 On a handshake with idx_last=1, the block SHALL return to IDLE and pulse done the next cycle; load_ready SHALL be 1 that same cycle.
REQ-025 remaining SHALL equal the popcount of the registered mask; 0 in IDLE; a full mask SHALL give N_REGS (width IDX_W+1 avoids overflow).
REQ-026 abort SHALL have priority over all other inputs: clear mask, go to IDLE, no done pulse; abort in IDLE SHALL also block a load that cycle.
REQ-027 load_valid in EMIT SHALL be ignored with no state change.

Reset
REQ-028 While rst_n=0: state=IDLE, mask=0, idx_valid=0, idx=0, idx_onehot=0, idx_last=0, remaining=0, done=0, load_ready=1.
REQ-029 Reset asserted mid-job SHALL discard the job without a done pulse; first load SHALL be accepted on the first clk edge after rst_n rises.

Structure
REQ-030 N_REGS, IDX_W and the state enumeration SHALL reside in shared package register_pkg.
REQ-031 The lowest-set-bit search SHALL be a combinational sub-module lsb_encoder (mask in, index and any-set out).
REQ-032 All outputs except load_ready SHALL be driven by registers or by the registered mask through lsb_encoder only; no input-to-output combinational path except abort/idx_ready gating state.

Verification
REQ-033 Load 32'h8000_0011, idx_ready=1 -> idx 0,4,31 on consecutive cycles, idx_last only on 31, remaining 3,2,1, done one cycle after 31.
REQ-034 Load 32'h0000_0000 -> no idx_valid, done pulses 1 cycle after accept, load_ready stays 1.
REQ-035 Load 32'hFFFF_FFFF, idx_ready=1 -> remaining starts at 32, idx 0..31 over 32 cycles, done at cycle 33.
REQ-036 Load 32'h0000_0006, idx_ready low 3 cycles -> idx=1 held stable with idx_onehot=32'h2, then 1, 2 emitted.
REQ-037 Load 32'h0000_00F0, abort after idx 4 accepted -> IDLE next cycle, no done, remaining=0; new load 32'h1 emits idx 0.
REQ-038 Load 32'h0000_0300, rst_n low after first handshake -> all outputs at reset values immediately; no done.
